sampletrig: RTL and testbench
=============================

SAMPLETRIG -- requirements
Module: sampletrig

Interface
REQ-001 Parameter HOLDOFF_W, default 16, width of holdoff counter and register.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_sample  input  32  raw measurement sample; ch0 = [15:0], ch1 = [31:16], each signed.
REQ-005 in_avail  input  1  in_sample valid this cycle.
REQ-006 sample  output  32  registered copy of in_sample, to sampleq sample.
REQ-007 sample_avail  output  1  registered copy of in_avail, to sampleq sample_avail.
REQ-008 trigger  output  1  one-cycle pulse, asserted only together with sample_avail, to sampleq trigger.
REQ-009 wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  register bus strobe/cycle/write.
REQ-010 wb_adr_i  input  16; wb_dat_i  input  8; wb_dat_o  output  8; wb_ack_o  output  1, tied to 1.

Function
REQ-011 Data path latency: exactly 1 cycle from in_sample/in_avail to sample/sample_avail, with no gaps or reordering.
REQ-012 Write strobe = wb_cyc_i && wb_stb_i && wb_we_i; decode on wb_adr_i[3:0]; wb_dat_o is combinational on wb_adr_i[3:0].
REQ-013 Register map:
- 0 CTRL rw: [1:0] mode (0 off, 1 rising, 2 falling, 3 either), [2] channel select, [3] enable.
- 1 STATUS ro: [2:0] FSM state code.
- 2-3 THRESH: signed 16-bit, low byte first.
- 4-5 HYST: unsigned 16-bit.
- 6-7 HOLDOFF: HOLDOFF_W bits.
- 8-11 TRIGCNT ro: 32-bit trigger count.
- 12-13 TRIGVAL ro: channel value of the last firing sample.
- 14-15: read 0.
REQ-014 Writes to THRESH/HYST/HOLDOFF are ignored while CTRL.enable=1; CTRL is always writable.
REQ-015 v = selected 16-bit channel of in_sample, sign-extended to 18 bits; lo = THRESH-HYST and hi = THRESH+HYST are computed in 18-bit signed, so they never wrap.
REQ-016 FSM states: OFF(0), ARMING(1), ARMED_LO(2), ARMED_HI(3), HOLDOFF(4).
REQ-017 Any state goes to OFF in the cycle after a CTRL write with enable=0 or mode=0; this takes priority over all other transitions.
REQ-018 OFF goes to ARMING in the cycle after a CTRL write with enable=1 and mode!=0.
REQ-019 The FSM evaluates only on cycles with in_avail=1.
REQ-020 ARMING transitions:
- v<=lo and mode is rising or either -> ARMED_LO.
- v>=hi and mode is falling or either -> ARMED_HI.
- Otherwise stay.
REQ-021 ARMED_LO with v>=THRESH fires; ARMED_HI with v<=THRESH fires.
REQ-022 On fire:
- trigger=1 in the same cycle that this sample appears on sample_avail.
- TRIGCNT increments (wraps at 2^32).
- TRIGVAL captures v[15:0].
- State goes to HOLDOFF with the counter loaded from HOLDOFF.
REQ-023 HOLDOFF decrements on each in_avail and goes to ARMING on the sample where the counter is 0; HOLDOFF=0 means ARMING on the next sample.
REQ-024 HYST=0 is legal: a sample equal to THRESH arms; firing then needs a later sample.
REQ-025 A sample that arms never fires in the same cycle.
REQ-026 A CTRL mode change while enabled restarts at ARMING, and TRIGCNT is preserved.
REQ-027 A CTRL write in the same cycle as a fire: the fire still reports, and the CTRL transition wins for the next state.

Reset
REQ-028 rst_n low asynchronously clears:
- sample, sample_avail, trigger -> 0.
- FSM -> OFF.
- CTRL, THRESH, HYST, HOLDOFF, TRIGCNT, TRIGVAL, holdoff counter -> 0.
REQ-029 The first in_avail after rst_n deasserts is passed through normally.
REQ-030 Reset mid-frame drops any pending trigger.

Structure
REQ-031 Shared package holds:
- FSM state encoding constants.
- Mode constants.
- CTRL bit positions.
- Register address constants 0-15.
REQ-032 One sub-module, trig_compare: combinational 18-bit lo/hi/threshold comparator returning the arm_lo, arm_hi, fire_up and fire_dn flags.
REQ-033 Target 150-300 lines of RTL; no memories.

Verification
REQ-034 Rising: THRESH=100, HYST=10, mode=1, ch0, enable; samples 50,95,89,99,100,120 -> one trigger on the sample 100 (cycle+1), TRIGCNT=1, TRIGVAL=100.
REQ-035 Falling, HOLDOFF=3: THRESH=0, HYST=5; samples 10,0,10,-1,-1,-1,10,-3 -> trigger on the first 0; holdoff absorbs the next three samples; ARMING re-arms on 10; trigger on -3; TRIGCNT=2.
REQ-036 Either mode, ch1, negative threshold THRESH=-32768, HYST=1: ch1 samples -32768,32767,-32768 -> lo computed without wrap; arming occurs only as hi-side; trigger on the second -32768.
REQ-037 Back-to-back in_avail for 1000 cycles with random gaps -> sample/sample_avail equal inputs delayed exactly 1 cycle; trigger is never high without sample_avail.
REQ-038 Write THRESH while enabled -> readback unchanged. Write CTRL enable=0 during HOLDOFF -> STATUS=0 next cycle.
REQ-039 Assert rst_n low during ARMED_LO -> all outputs 0 immediately (asynchronous), STATUS=0, TRIGCNT=0.

Source files
------------

// File: rtl/sampletrig_pkg.sv
// rtl/sampletrig_pkg.sv - shared state, mode, control-bit and register-address constants for sampletrig
package sampletrig_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_ARMING   = 3'd1,
    ST_ARMED_LO = 3'd2,
    ST_ARMED_HI = 3'd3,
    ST_HOLDOFF  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_RISE   = 2'd1;
  localparam logic [1:0] MODE_FALL   = 2'd2;
  localparam logic [1:0] MODE_EITHER = 2'd3;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_CHSEL    = 2;
  localparam int CTRL_EN       = 3;

  localparam logic [3:0] ADDR_CTRL       = 4'd0;
  localparam logic [3:0] ADDR_STATUS     = 4'd1;
  localparam logic [3:0] ADDR_THRESH_LO  = 4'd2;
  localparam logic [3:0] ADDR_THRESH_HI  = 4'd3;
  localparam logic [3:0] ADDR_HYST_LO    = 4'd4;
  localparam logic [3:0] ADDR_HYST_HI    = 4'd5;
  localparam logic [3:0] ADDR_HOLDOFF_LO = 4'd6;
  localparam logic [3:0] ADDR_HOLDOFF_HI = 4'd7;
  localparam logic [3:0] ADDR_TRIGCNT0   = 4'd8;
  localparam logic [3:0] ADDR_TRIGCNT1   = 4'd9;
  localparam logic [3:0] ADDR_TRIGCNT2   = 4'd10;
  localparam logic [3:0] ADDR_TRIGCNT3   = 4'd11;
  localparam logic [3:0] ADDR_TRIGVAL_LO = 4'd12;
  localparam logic [3:0] ADDR_TRIGVAL_HI = 4'd13;
  localparam logic [3:0] ADDR_RSVD_14    = 4'd14;
  localparam logic [3:0] ADDR_RSVD_15    = 4'd15;

  function automatic logic mode_has_rise(input logic [1:0] m);
    return (m == MODE_RISE) || (m == MODE_EITHER);
  endfunction

  function automatic logic mode_has_fall(input logic [1:0] m);
    return (m == MODE_FALL) || (m == MODE_EITHER);
  endfunction

endpackage

// File: rtl/sampletrig_trig_compare.sv
// rtl/sampletrig_trig_compare.sv - 18-bit signed comparison of a sample against threshold and hysteresis band
module trig_compare
  import sampletrig_pkg::*;
(
  input  logic signed [17:0] v,
  input  logic        [15:0] thresh,
  input  logic        [15:0] hyst,
  output logic               arm_lo,
  output logic               arm_hi,
  output logic               fire_up,
  output logic               fire_dn
);

  logic signed [17:0] thr_s;
  logic signed [17:0] hyst_s;
  logic signed [17:0] lo;
  logic signed [17:0] hi;

  // Two guard bits keep THRESH +/- HYST exact over the full 16-bit ranges.
  always_comb begin
    thr_s   = {{2{thresh[15]}}, thresh};
    hyst_s  = {2'b00, hyst};
    lo      = thr_s - hyst_s;
    hi      = thr_s + hyst_s;
    arm_lo  = (v <= lo);
    arm_hi  = (v >= hi);
    fire_up = (v >= thr_s);
    fire_dn = (v <= thr_s);
  end

endmodule

// File: rtl/sampletrig.sv
// rtl/sampletrig.sv - sample pass-through with hysteresis level trigger, holdoff and byte-wide register bus
module sampletrig
  import sampletrig_pkg::*;
#(
  parameter int HOLDOFF_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_sample,
  input  logic        in_avail,
  output logic [31:0] sample,
  output logic        sample_avail,
  output logic        trigger,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o
);

  state_e               state_q, state_d;
  logic [3:0]           ctrl_q, ctrl_d;
  logic [15:0]          thresh_q, thresh_d;
  logic [15:0]          hyst_q, hyst_d;
  logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
  logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
  logic [31:0]          trigcnt_q, trigcnt_d;
  logic [15:0]          trigval_q, trigval_d;
  logic [31:0]          sample_q, sample_d;
  logic                 avail_q, avail_d;
  logic                 trig_q, trig_d;

  logic                 wr_en;
  logic                 ctrl_wr;
  logic                 cfg_wr_ok;
  logic                 fire;
  logic [3:0]           adr;
  logic [11:0]          adr_unused;
  logic [1:0]           mode;
  logic [15:0]          ch;
  logic signed [17:0]   v;
  logic [15:0]          ho_img;
  logic [15:0]          ho_new;
  logic                 arm_lo, arm_hi, fire_up, fire_dn;

  assign adr        = wb_adr_i[3:0];
  assign adr_unused = wb_adr_i[15:4];
  assign wr_en      = wb_cyc_i && wb_stb_i && wb_we_i;
  assign ctrl_wr    = wr_en && (adr == ADDR_CTRL);
  assign cfg_wr_ok  = wr_en && !ctrl_q[CTRL_EN];
  assign mode       = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign ch         = ctrl_q[CTRL_CHSEL] ? in_sample[31:16] : in_sample[15:0];
  assign v          = {{2{ch[15]}}, ch};
  assign ho_img     = 16'(holdoff_q);

  trig_compare u_cmp (
    .v       (v),
    .thresh  (thresh_q),
    .hyst    (hyst_q),
    .arm_lo  (arm_lo),
    .arm_hi  (arm_hi),
    .fire_up (fire_up),
    .fire_dn (fire_dn)
  );

  // A CTRL write overrides whatever the sample stream decided this cycle.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    fire    = 1'b0;
    if (in_avail) begin
      case (state_q)
        ST_ARMING: begin
          if (arm_lo && mode_has_rise(mode)) begin
            state_d = ST_ARMED_LO;
          end else if (arm_hi && mode_has_fall(mode)) begin
            state_d = ST_ARMED_HI;
          end
        end
        ST_ARMED_LO: fire = fire_up;
        ST_ARMED_HI: fire = fire_dn;
        ST_HOLDOFF: begin
          if (hcnt_q == '0) begin
            state_d = ST_ARMING;
          end else begin
            hcnt_d = hcnt_q - HOLDOFF_W'(1);
          end
        end
        default: ;
      endcase
    end
    if (fire) begin
      state_d = ST_HOLDOFF;
      hcnt_d  = holdoff_q;
    end
    if (ctrl_wr) begin
      if (wb_dat_i[CTRL_EN] && (wb_dat_i[CTRL_MODE_MSB:CTRL_MODE_LSB] != MODE_OFF)) begin
        state_d = ST_ARMING;
      end else begin
        state_d = ST_OFF;
      end
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    thresh_d = thresh_q;
    hyst_d   = hyst_q;
    ho_new   = ho_img;
    if (ctrl_wr) begin
      ctrl_d = wb_dat_i[3:0];
    end
    if (cfg_wr_ok) begin
      case (adr)
        ADDR_THRESH_LO:  thresh_d[7:0]  = wb_dat_i;
        ADDR_THRESH_HI:  thresh_d[15:8] = wb_dat_i;
        ADDR_HYST_LO:    hyst_d[7:0]    = wb_dat_i;
        ADDR_HYST_HI:    hyst_d[15:8]   = wb_dat_i;
        ADDR_HOLDOFF_LO: ho_new[7:0]    = wb_dat_i;
        ADDR_HOLDOFF_HI: ho_new[15:8]   = wb_dat_i;
        default: ;
      endcase
    end
    holdoff_d = HOLDOFF_W'(ho_new);
    trigcnt_d = trigcnt_q + 32'(fire);
    trigval_d = fire ? ch : trigval_q;
    sample_d  = in_sample;
    avail_d   = in_avail;
    trig_d    = fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      ctrl_q    <= '0;
      thresh_q  <= '0;
      hyst_q    <= '0;
      holdoff_q <= '0;
      hcnt_q    <= '0;
      trigcnt_q <= '0;
      trigval_q <= '0;
      sample_q  <= '0;
      avail_q   <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      thresh_q  <= thresh_d;
      hyst_q    <= hyst_d;
      holdoff_q <= holdoff_d;
      hcnt_q    <= hcnt_d;
      trigcnt_q <= trigcnt_d;
      trigval_q <= trigval_d;
      sample_q  <= sample_d;
      avail_q   <= avail_d;
      trig_q    <= trig_d;
    end
  end

  always_comb begin
    wb_dat_o = 8'h00;
    case (adr)
      ADDR_CTRL:       wb_dat_o = {4'h0, ctrl_q};
      ADDR_STATUS:     wb_dat_o = {5'h00, state_q};
      ADDR_THRESH_LO:  wb_dat_o = thresh_q[7:0];
      ADDR_THRESH_HI:  wb_dat_o = thresh_q[15:8];
      ADDR_HYST_LO:    wb_dat_o = hyst_q[7:0];
      ADDR_HYST_HI:    wb_dat_o = hyst_q[15:8];
      ADDR_HOLDOFF_LO: wb_dat_o = ho_img[7:0];
      ADDR_HOLDOFF_HI: wb_dat_o = ho_img[15:8];
      ADDR_TRIGCNT0:   wb_dat_o = trigcnt_q[7:0];
      ADDR_TRIGCNT1:   wb_dat_o = trigcnt_q[15:8];
      ADDR_TRIGCNT2:   wb_dat_o = trigcnt_q[23:16];
      ADDR_TRIGCNT3:   wb_dat_o = trigcnt_q[31:24];
      ADDR_TRIGVAL_LO: wb_dat_o = trigval_q[7:0];
      ADDR_TRIGVAL_HI: wb_dat_o = trigval_q[15:8];
      ADDR_RSVD_14, ADDR_RSVD_15: wb_dat_o = 8'h00;
      default:         wb_dat_o = 8'h00;
    endcase
  end

  assign sample       = sample_q;
  assign sample_avail = avail_q;
  assign trigger      = trig_q;
  assign wb_ack_o     = 1'b1;

endmodule

// File: tb/tb_sampletrig.sv
// tb/tb_sampletrig.sv - directed and randomized bench for sampletrig against an integer reference model
module tb_sampletrig;
  import sampletrig_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_sample;
  logic        in_avail;
  logic [31:0] sample;
  logic        sample_avail;
  logic        trigger;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic [15:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;

  int checks = 0;
  int errors = 0;

  bit [3:0]  m_ctrl;
  bit [15:0] m_thr, m_hyst, m_hold, m_trigval;
  bit [31:0] m_trigcnt;
  int        m_st, m_cnt;

  int s34[6]  = '{50, 95, 89, 99, 100, 120};
  bit t34[6]  = '{0, 0, 0, 0, 1, 0};
  int s35[8]  = '{10, 0, 10, -1, -1, -1, 10, -3};
  bit t35[8]  = '{0, 1, 0, 0, 0, 0, 0, 1};
  int st35[8] = '{3, 4, 4, 4, 4, 1, 3, 4};
  int s36[3]  = '{-32768, 32767, -32768};
  bit t36[3]  = '{0, 0, 1};
  int st36[3] = '{1, 3, 4};

  always #5 clk = ~clk;

  sampletrig #(.HOLDOFF_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_sample    (in_sample),
    .in_avail     (in_avail),
    .sample       (sample),
    .sample_avail (sample_avail),
    .trigger      (trigger),
    .wb_stb_i     (wb_stb_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_we_i      (wb_we_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void m_reset();
    m_ctrl = 0; m_thr = 0; m_hyst = 0; m_hold = 0;
    m_trigval = 0; m_trigcnt = 0; m_st = 0; m_cnt = 0;
  endfunction

  // Integer model: band edges computed in int, so no width tricks are needed.
  function automatic bit m_step(input bit av, input logic [31:0] d, input bit wr,
                                input logic [3:0] a, input logic [7:0] dat);
    int v, thr, lo, hi, nst;
    bit rise, fall, fire, old_en;
    logic [15:0] ch;
    fire   = 0;
    nst    = m_st;
    old_en = m_ctrl[3];
    ch     = m_ctrl[2] ? d[31:16] : d[15:0];
    v      = $signed(ch);
    thr    = $signed(m_thr);
    lo     = thr - int'(m_hyst);
    hi     = thr + int'(m_hyst);
    rise   = (m_ctrl[1:0] == 2'd1) || (m_ctrl[1:0] == 2'd3);
    fall   = (m_ctrl[1:0] >= 2'd2);
    if (av) begin
      case (m_st)
        1: if (rise && v <= lo) nst = 2; else if (fall && v >= hi) nst = 3;
        2: fire = (v >= thr);
        3: fire = (v <= thr);
        4: if (m_cnt == 0) nst = 1; else m_cnt--;
        default: ;
      endcase
    end
    if (fire) begin
      m_trigcnt++;
      m_trigval = ch;
      nst = 4;
      m_cnt = int'(m_hold);
    end
    if (wr) begin
      case (a)
        4'd0: begin m_ctrl = dat[3:0]; nst = (dat[3] && dat[1:0] != 2'd0) ? 1 : 0; end
        4'd2: if (!old_en) m_thr[7:0]   = dat;
        4'd3: if (!old_en) m_thr[15:8]  = dat;
        4'd4: if (!old_en) m_hyst[7:0]  = dat;
        4'd5: if (!old_en) m_hyst[15:8] = dat;
        4'd6: if (!old_en) m_hold[7:0]  = dat;
        4'd7: if (!old_en) m_hold[15:8] = dat;
        default: ;
      endcase
    end
    m_st = nst;
    return fire;
  endfunction

  task automatic tick(input bit av, input logic [31:0] d, input bit wr,
                      input logic [3:0] a, input logic [7:0] dat);
    bit et;
    in_avail = av; in_sample = d;
    wb_cyc_i = wr; wb_stb_i = wr; wb_we_i = wr;
    wb_adr_i = {12'h000, a}; wb_dat_i = dat;
    @(posedge clk);
    #1;
    et = m_step(av, d, wr, a, dat);
    chk("sample", sample, d);
    chk("sample_avail", 32'(sample_avail), 32'(av));
    chk("trigger", 32'(trigger), 32'(et));
    chk("trig_without_avail", 32'(trigger & ~sample_avail), 32'd0);
    in_avail = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic smp(input logic [15:0] c0, input logic [15:0] c1);
    tick(1'b1, {c1, c0}, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic wreg(input logic [3:0] a, input logic [7:0] dat);
    tick(1'b0, $urandom, 1'b1, a, dat);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] expv, input string tag);
    tick(1'b0, $urandom, 1'b0, 4'h0, 8'h00);
    wb_adr_i = {12'h000, a};
    #1;
    chk(tag, {24'h0, wb_dat_o}, {24'h0, expv});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_avail = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    rst_n = 1'b0; in_sample = 32'h0; in_avail = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 16'h0; wb_dat_i = 8'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sample", sample, 32'd0);
    chk("reset_avail", 32'(sample_avail), 32'd0);
    chk("reset_trigger", 32'(trigger), 32'd0);
    chk("reset_ack", 32'(wb_ack_o), 32'd1);
    rst_n = 1'b1;
    rd(ADDR_STATUS, 8'd0, "reset_status");
    rd(ADDR_CTRL, 8'd0, "reset_ctrl");
    rd(ADDR_TRIGCNT0, 8'd0, "reset_trigcnt");

    // Rising, THRESH=100 HYST=10
    wreg(ADDR_THRESH_LO, 8'd100); wreg(ADDR_THRESH_HI, 8'd0);
    wreg(ADDR_HYST_LO, 8'd10);    wreg(ADDR_HYST_HI, 8'd0);
    wreg(ADDR_HOLDOFF_LO, 8'd0);  wreg(ADDR_HOLDOFF_HI, 8'd0);
    wreg(ADDR_CTRL, 8'h09);
    rd(ADDR_STATUS, 8'd1, "rise_arming");
    for (int i = 0; i < 6; i++) begin
      smp(16'(s34[i]), 16'($urandom));
      chk("rise_seq_trig", 32'(trigger), 32'(t34[i]));
    end
    rd(ADDR_TRIGCNT0, 8'd1, "rise_trigcnt0");
    rd(ADDR_TRIGCNT1, 8'd0, "rise_trigcnt1");
    rd(ADDR_TRIGVAL_LO, 8'd100, "rise_trigval_lo");
    rd(ADDR_TRIGVAL_HI, 8'd0, "rise_trigval_hi");
    rd(ADDR_STATUS, 8'd1, "rise_rearm_status");
    wreg(ADDR_THRESH_LO, 8'h55);
    rd(ADDR_THRESH_LO, 8'd100, "thresh_locked");
    rd(ADDR_RSVD_14, 8'd0, "rsvd14");

    // HYST=0: equal sample arms, the next equal sample fires
    wreg(ADDR_CTRL, 8'h00);
    wreg(ADDR_THRESH_LO, 8'd20); wreg(ADDR_HYST_LO, 8'd0);
    wreg(ADDR_CTRL, 8'h09);
    smp(16'd20, 16'h0);
    chk("hyst0_arm_no_fire", 32'(trigger), 32'd0);
    smp(16'd20, 16'h0);
    chk("hyst0_fire", 32'(trigger), 32'd1);

    // Falling with HOLDOFF=3
    do_reset();
    wreg(ADDR_THRESH_LO, 8'd0);  wreg(ADDR_THRESH_HI, 8'd0);
    wreg(ADDR_HYST_LO, 8'd5);    wreg(ADDR_HOLDOFF_LO, 8'd3);
    wreg(ADDR_CTRL, 8'h0A);
    for (int i = 0; i < 8; i++) begin
      smp(16'(s35[i]), 16'($urandom));
      chk("fall_seq_trig", 32'(trigger), 32'(t35[i]));
      rd(ADDR_STATUS, 8'(st35[i]), "fall_seq_status");
    end
    rd(ADDR_TRIGCNT0, 8'd2, "fall_trigcnt");
    wreg(ADDR_CTRL, 8'h00);
    chk("holdoff_disable_status", {24'h0, wb_dat_o}, 32'd0);
    rd(ADDR_STATUS, 8'd0, "holdoff_disable_status_rd");

    // Either, ch1, THRESH=-32768 HYST=1
    wreg(ADDR_THRESH_LO, 8'h00); wreg(ADDR_THRESH_HI, 8'h80);
    wreg(ADDR_HYST_LO, 8'd1);    wreg(ADDR_HOLDOFF_LO, 8'd0);
    wreg(ADDR_CTRL, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      smp(16'($urandom), 16'(s36[i]));
      chk("neg_seq_trig", 32'(trigger), 32'(t36[i]));
      rd(ADDR_STATUS, 8'(st36[i]), "neg_seq_status");
    end
    rd(ADDR_TRIGVAL_HI, 8'h80, "neg_trigval_hi");
    wreg(ADDR_CTRL, 8'h09);
    rd(ADDR_STATUS, 8'd1, "mode_change_arming");
    rd(ADDR_TRIGCNT0, 8'd3, "mode_change_trigcnt");

    // Asynchronous reset while ARMED_LO, with a firing sample pending
    wreg(ADDR_CTRL, 8'h00);
    wreg(ADDR_THRESH_LO, 8'd100); wreg(ADDR_THRESH_HI, 8'd0);
    wreg(ADDR_HYST_LO, 8'd10);
    wreg(ADDR_CTRL, 8'h09);
    smp(16'd50, 16'h0);
    rd(ADDR_STATUS, 8'd2, "armed_lo_status");
    smp(16'd60, 16'h0);
    in_avail = 1'b1; in_sample = {16'h0, 16'd100};
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sample", sample, 32'd0);
    chk("async_rst_avail", 32'(sample_avail), 32'd0);
    chk("async_rst_trigger", 32'(trigger), 32'd0);
    wb_adr_i = {12'h000, ADDR_STATUS};
    #1;
    chk("async_rst_status", {24'h0, wb_dat_o}, 32'd0);
    wb_adr_i = {12'h000, ADDR_TRIGCNT0};
    #1;
    chk("async_rst_trigcnt", {24'h0, wb_dat_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_dropped_trigger", 32'(trigger), 32'd0);
    chk("rst_dropped_avail", 32'(sample_avail), 32'd0);
    in_avail = 1'b0;
    rst_n = 1'b1;
    m_reset();
    smp(16'd7, 16'd9);

    // Randomized traffic with gaps, register writes and mode changes
    wreg(ADDR_THRESH_LO, 8'($urandom)); wreg(ADDR_THRESH_HI, 8'($urandom_range(0, 1)));
    wreg(ADDR_HYST_LO, 8'($urandom_range(0, 40)));
    wreg(ADDR_HOLDOFF_LO, 8'($urandom_range(0, 4)));
    wreg(ADDR_CTRL, 8'h0B);
    for (int i = 0; i < 1000; i++) begin
      bit av, wr;
      logic [3:0] a;
      logic [7:0] dat;
      logic [15:0] c0, c1;
      int base;
      av   = ($urandom_range(0, 9) < 7);
      base = $signed(m_thr);
      c0   = 16'(base + int'($urandom_range(0, 120)) - 60);
      c1   = 16'(base + int'($urandom_range(0, 120)) - 60);
      if ($urandom_range(0, 15) == 0) c0 = 16'($urandom);
      wr   = ($urandom_range(0, 7) == 0);
      a    = 4'($urandom_range(0, 9));
      dat  = 8'($urandom);
      if (a == ADDR_CTRL && $urandom_range(0, 3) != 0) dat[3] = 1'b1;
      if (a == ADDR_HYST_HI || a == ADDR_HOLDOFF_HI) dat = 8'h00;
      if (a == ADDR_HOLDOFF_LO) dat = 8'($urandom_range(0, 6));
      tick(av, {c1, c0}, wr, a, dat);
      if (i % 100 == 99) begin
        rd(ADDR_STATUS, 8'(m_st), "rnd_status");
        rd(ADDR_TRIGCNT0, m_trigcnt[7:0], "rnd_trigcnt");
        rd(ADDR_TRIGVAL_LO, m_trigval[7:0], "rnd_trigval");
        rd(ADDR_CTRL, {4'h0, m_ctrl}, "rnd_ctrl");
        rd(ADDR_THRESH_LO, m_thr[7:0], "rnd_thresh");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
